// File: rtl/goose_pkg.sv
// goose_pkg: shared state encodings, video timing constants and score width for the goose game.
package goose_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RESTART = 2'd1, ST_PLAY = 2'd2, ST_OVER = 2'd3} state_t;
  localparam int H_TOTAL = 800;
  localparam int V_TOTAL = 525;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int SCORE_W = 10;
endpackage

// File: rtl/collision_ctrl_if.sv
// collision_ctrl_if: pixel/hit link between the obstacle renderer and the collision controller.
interface collision_ctrl_if;
  logic pixel_tick;
  logic [9:0] x;
  logic [9:0] y;
  logic video_on;
  logic bean;
  logic goose;
  logic check_hit;
  logic game_reset;
  modport master (output pixel_tick, x, y, video_on, bean, goose, input check_hit, game_reset);
  modport slave (input pixel_tick, x, y, video_on, bean, goose, output check_hit, game_reset);
endinterface

// File: rtl/collision_ctrl_debounce.sv
// btn_debounce: two-flop synchroniser, stability counter and one-clk rising-edge pulse.
module btn_debounce #(
  parameter int DEBOUNCE = 250000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic level;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], din};
      press <= 1'b0;
      if (sync[1] == level) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE - 1)) begin
        cnt   <= '0;
        level <= sync[1];
        press <= sync[1];
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/collision_ctrl.sv
// collision_ctrl: per-frame bean/goose overlap detection, game FSM, score and high score.
module collision_ctrl
  import goose_pkg::*;
#(
  parameter int HIT_THRESH = 4,
  parameter int SCORE_DIV  = 6,
  parameter int SCORE_MAX  = 999,
  parameter int DEBOUNCE   = 250000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         button,
  collision_ctrl_if.slave    px,
  output logic [1:0]         state,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score
);
  localparam int FW = SCORE_DIV > 1 ? $clog2(SCORE_DIV) : 1;
  state_t st;
  logic fe, hit_px, press;
  logic [9:0] ov_cnt, ov_next;
  logic [FW-1:0] fcnt;
  assign state  = st;
  assign fe     = px.pixel_tick && px.x == 10'(H_TOTAL - 1) && px.y == 10'(V_TOTAL - 1);
  assign hit_px = px.pixel_tick && px.video_on && px.bean && px.goose;
  // the frame-end decision must include the pixel arriving on that same tick
  assign ov_next = (hit_px && ov_cnt != 10'h3FF) ? ov_cnt + 10'd1 : ov_cnt;
  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_btn (
    .clk(clk),
    .reset_n(reset_n),
    .din(button[0] | button[1]),
    .press(press)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ov_cnt <= '0;
    else ov_cnt <= fe ? '0 : ov_next;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st            <= ST_IDLE;
      px.check_hit  <= 1'b1;
      px.game_reset <= 1'b0;
      score         <= '0;
      high_score    <= '0;
      fcnt          <= '0;
    end else begin
      px.game_reset <= 1'b0;
      case (st)
        ST_IDLE, ST_OVER: if (press) begin
          st            <= ST_RESTART;
          px.game_reset <= 1'b1;
          score         <= '0;
          fcnt          <= '0;
        end
        ST_RESTART: begin
          st           <= ST_PLAY;
          px.check_hit <= 1'b0;
        end
        default: if (fe) begin
          if (ov_next >= 10'(HIT_THRESH)) begin
            st           <= ST_OVER;
            px.check_hit <= 1'b1;
            high_score   <= score > high_score ? score : high_score;
          end else if (fcnt == FW'(SCORE_DIV - 1)) begin
            fcnt  <= '0;
            score <= score == SCORE_W'(SCORE_MAX) ? score : score + 1'b1;
          end else fcnt <= fcnt + 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_collision_ctrl.sv
// tb_collision_ctrl: randomized frames and button sequences scored against a game-level model.
module tb_collision_ctrl;
  import goose_pkg::*;
  typedef struct packed {
    logic [1:0] st;
    logic       ch;
    logic       gr;
    logic [9:0] sc;
    logic [9:0] hs;
  } snap_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] button = 2'b00;
  logic [1:0] state;
  logic [9:0] score, high_score;
  collision_ctrl_if bus ();
  collision_ctrl #(.DEBOUNCE(4)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .button(button),
    .px(bus.slave),
    .state(state),
    .score(score),
    .high_score(high_score)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  snap_t exp_q[$];
  snap_t prev, cur;
  bit mon_en = 0;
  state_t m_st = ST_IDLE;
  int m_score = 0, m_hs = 0, m_fcnt = 0;
  bit m_lvl = 0;
  function automatic snap_t mk(state_t s, bit gr, int sc, int hs);
    snap_t r;
    r.st = s; r.ch = (s != ST_PLAY); r.gr = gr; r.sc = 10'(sc); r.hs = 10'(hs);
    return r;
  endfunction
  function automatic snap_t dut_snap();
    snap_t r;
    r.st = state; r.ch = bus.check_hit; r.gr = bus.game_reset; r.sc = score; r.hs = high_score;
    return r;
  endfunction
  task automatic check(string name, snap_t got, snap_t want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got st=%0d ch=%0b gr=%0b sc=%0d hs=%0d, want st=%0d ch=%0b gr=%0b sc=%0d hs=%0d",
               name, got.st, got.ch, got.gr, got.sc, got.hs, want.st, want.ch, want.gr, want.sc, want.hs);
    end
  endtask
  // monitor: every visible change of the output tuple must match the next predicted event
  always @(negedge clk) begin
    cur = dut_snap();
    if (mon_en && cur !== prev) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_change: got st=%0d ch=%0b gr=%0b sc=%0d hs=%0d, want no change",
                 cur.st, cur.ch, cur.gr, cur.sc, cur.hs);
      end else check("event", cur, exp_q.pop_front());
    end
    prev = cur;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic pix(bit t, int px_x, int px_y, bit von, bit b, bit g);
    bus.pixel_tick = t; bus.x = 10'(px_x); bus.y = 10'(px_y);
    bus.video_on = von; bus.bean = b; bus.goose = g;
    step();
  endtask
  task automatic frame(int nov);
    if (m_st == ST_PLAY) begin
      if (nov >= 4) begin
        m_st = ST_OVER;
        if (m_score > m_hs) m_hs = m_score;
        exp_q.push_back(mk(ST_OVER, 0, m_score, m_hs));
      end else if (++m_fcnt == 6) begin
        m_fcnt = 0;
        if (m_score < 999) begin
          m_score++;
          exp_q.push_back(mk(ST_PLAY, 0, m_score, m_hs));
        end
      end
    end
    for (int i = 0; i < nov; i++)
      pix(1, $urandom_range(0, H_ACTIVE - 1), $urandom_range(0, V_ACTIVE - 1), 1, 1, 1);
    for (int i = $urandom_range(0, 2); i > 0; i--)
      case ($urandom_range(0, 3))
        0: pix(0, $urandom_range(0, H_ACTIVE - 1), $urandom_range(0, V_ACTIVE - 1), 1, 1, 1);
        1: pix(1, $urandom_range(H_ACTIVE, H_TOTAL - 2), $urandom_range(0, V_ACTIVE - 1), 0, 1, 1);
        2: pix(1, $urandom_range(0, H_ACTIVE - 1), $urandom_range(0, V_ACTIVE - 1), 1, 1, 0);
        default: pix(1, $urandom_range(0, H_ACTIVE - 1), $urandom_range(0, V_ACTIVE - 1), 1, 0, 1);
      endcase
    pix(1, H_TOTAL - 1, V_TOTAL - 1, 0, 1'($urandom), 1'($urandom));
    pix(0, 0, 0, 0, 0, 0);
  endtask
  task automatic btn_set(logic [1:0] v, int n);
    if (|v && !m_lvl && n >= 5) begin
      m_lvl = 1;
      if (m_st == ST_IDLE || m_st == ST_OVER) begin
        m_st = ST_PLAY; m_score = 0; m_fcnt = 0;
        exp_q.push_back(mk(ST_RESTART, 1, 0, m_hs));
        exp_q.push_back(mk(ST_PLAY, 0, 0, m_hs));
      end
    end else if (!(|v) && n >= 5) m_lvl = 0;
    button = v;
    repeat (n) step();
  endtask
  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() > 0; i++) step();
    if (exp_q.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d events pending, want 0", exp_q.size());
      exp_q.delete();
    end
    repeat (4) step();
  endtask
  task automatic check_model(string name);
    check(name, dut_snap(), mk(m_st, 0, m_score, m_hs));
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish before 2 ms");
    $fatal(1, "watchdog");
  end
  initial begin
    pix(0, 0, 0, 0, 0, 0);
    repeat (2) step();
    check("reset", dut_snap(), mk(ST_IDLE, 0, 0, 0));
    reset_n = 1'b1;
    step();
    check("post_reset", dut_snap(), mk(ST_IDLE, 0, 0, 0));
    mon_en = 1;
    btn_set(2'b01, 10);
    btn_set(2'b00, 10);
    drain();
    check("start_play", dut_snap(), mk(ST_PLAY, 0, 0, 0));
    repeat (12) frame($urandom_range(0, 3));
    drain();
    check("score_2", dut_snap(), mk(ST_PLAY, 0, 2, 0));
    repeat (18) frame($urandom_range(0, 3));
    frame(3);
    drain();
    check("below_thresh", dut_snap(), mk(ST_PLAY, 0, 5, 0));
    frame(4);
    drain();
    check("over_hs5", dut_snap(), mk(ST_OVER, 0, 5, 5));
    btn_set(2'b10, 10);
    btn_set(2'b00, 10);
    drain();
    repeat (12) frame($urandom_range(0, 3));
    frame($urandom_range(4, 9));
    drain();
    check("hs_kept", dut_snap(), mk(ST_OVER, 0, 2, 5));
    btn_set(2'b01, 10);
    btn_set(2'b00, 10);
    drain();
    btn_set(2'b10, 10);
    frame(5);
    repeat (10) step();
    drain();
    check("held_no_restart", dut_snap(), mk(ST_OVER, 0, 0, 5));
    btn_set(2'b00, 5);
    btn_set(2'b10, 5);
    btn_set(2'b00, 10);
    drain();
    check("re_press", dut_snap(), mk(ST_PLAY, 0, 0, 5));
    while (m_score < 999) frame($urandom_range(0, 3));
    repeat (12) frame($urandom_range(0, 3));
    drain();
    n_cmp++;
    if (score !== 10'd999) begin
      n_bad++;
      $display("FAIL saturate: got score=%0d, want 999", score);
    end
    check_model("saturate_model");
    frame(4);
    drain();
    check("over_999", dut_snap(), mk(ST_OVER, 0, 999, 999));
    for (int i = 0; i < 20; i++) begin
      button = i[0] ? 2'b01 : 2'b00;
      step();
    end
    button = 2'b00;
    repeat (20) step();
    drain();
    check("bounce", dut_snap(), mk(ST_OVER, 0, 999, 999));
    btn_set(2'b01, 10);
    btn_set(2'b00, 10);
    drain();
    repeat (18) frame($urandom_range(0, 3));
    drain();
    check("pre_reset", dut_snap(), mk(ST_PLAY, 0, 3, 999));
    bus.pixel_tick = 1; bus.video_on = 1; bus.bean = 1; bus.goose = 1;
    mon_en = 0;
    #2 reset_n = 1'b0;
    #1 check("async_reset", dut_snap(), mk(ST_IDLE, 0, 0, 0));
    m_st = ST_IDLE; m_score = 0; m_hs = 0; m_fcnt = 0; m_lvl = 0;
    pix(0, 0, 0, 0, 0, 0);
    step();
    check("reset_held", dut_snap(), mk(ST_IDLE, 0, 0, 0));
    reset_n = 1'b1;
    step();
    mon_en = 1;
    btn_set(2'b11, 10);
    btn_set(2'b00, 10);
    drain();
    check("restart_after_reset", dut_snap(), mk(ST_PLAY, 0, 0, 0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
